// File: rtl/soc_pkg.sv
// ---------------------------------------------------------------------------
// soc_pkg
//   Shared types and constants for the memory-port arbiter.
//   arb_state_t : arbiter FSM state encoding
//   LSU_* sizes : access size codes carried on lsu_size / io_size
// ---------------------------------------------------------------------------
package soc_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE     = 2'd0,
      ARB_BUSY_IFU = 2'd1,
      ARB_BUSY_LSU = 2'd2
   } arb_state_t;

   localparam logic [1:0] LSU_BYTE = 2'b00;
   localparam logic [1:0] LSU_HALF = 2'b01;
   localparam logic [1:0] LSU_WORD = 2'b10;
   localparam logic [1:0] LSU_EXTA = 2'b11;

endpackage

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Shares the single memory/IO port between the instruction fetch unit and
//   the LSU, one bus transaction outstanding at a time. The LSU has fixed
//   priority; a starvation counter lets the IFU win after IFU_MAX_WAIT
//   consecutive lost arbitrations.
//
// Ports
//   clock, reset                    clock, synchronous active-high reset
//   ifu_reqValid/ifu_addr           IFU request (held until ifu_respValid)
//   ifu_respValid/ifu_rdata         IFU completion and fetched word
//   lsu_reqValid/lsu_addr/lsu_wdata LSU request (held until lsu_respValid)
//   lsu_size/lsu_wen/lsu_wmask      LSU access attributes
//   lsu_respValid/lsu_rdata         LSU completion and read data
//   io_reqValid/io_addr/io_wdata    request towards the bus bridge
//   io_size/io_wen/io_wmask         muxed access attributes
//   io_respValid/io_rdata           bus completion (may be same cycle) and data
// ---------------------------------------------------------------------------
import soc_pkg::*;

module mem_arbiter #(
   parameter int IFU_MAX_WAIT = 4,
   parameter int CNT_W        = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ifu_reqValid,
   output logic        ifu_respValid,
   input  logic [31:0] ifu_addr,
   output logic [31:0] ifu_rdata,
   input  logic        lsu_reqValid,
   output logic        lsu_respValid,
   input  logic [31:0] lsu_addr,
   input  logic [31:0] lsu_wdata,
   input  logic [1:0]  lsu_size,
   input  logic        lsu_wen,
   input  logic [3:0]  lsu_wmask,
   output logic [31:0] lsu_rdata,
   output logic        io_reqValid,
   input  logic        io_respValid,
   output logic [31:0] io_addr,
   output logic [31:0] io_wdata,
   output logic [1:0]  io_size,
   output logic        io_wen,
   output logic [3:0]  io_wmask,
   input  logic [31:0] io_rdata
);

   localparam logic [CNT_W-1:0] MAX_WAIT = CNT_W'(IFU_MAX_WAIT);

   arb_state_t       state;
   arb_state_t       next_state;
   logic [CNT_W-1:0] wait_cnt;
   logic             arb_lsu;
   logic             arb_ifu;
   logic             sel_lsu;
   logic             sel_ifu;

   // Read data is broadcast; each consumer qualifies it with its own respValid.
   assign ifu_rdata = io_rdata;
   assign lsu_rdata = io_rdata;

   // Grant decision, request mux and response routing. Arbitration happens
   // only in IDLE; a busy state keeps the bus locked to its owner until the
   // bridge responds, even if the owner drops its request. Everything is
   // forced quiet while reset is high.
   always_comb begin
      next_state    = state;
      arb_lsu       = 1'b0;
      arb_ifu       = 1'b0;
      sel_lsu       = 1'b0;
      sel_ifu       = 1'b0;
      io_reqValid   = 1'b0;
      io_addr       = '0;
      io_wdata      = '0;
      io_size       = '0;
      io_wen        = 1'b0;
      io_wmask      = '0;
      ifu_respValid = 1'b0;
      lsu_respValid = 1'b0;
      if (!reset) begin
         case (state)
            ARB_IDLE: begin
               arb_lsu = lsu_reqValid && !(ifu_reqValid && (wait_cnt == MAX_WAIT));
               arb_ifu = ifu_reqValid && !arb_lsu;
               sel_lsu = arb_lsu;
               sel_ifu = arb_ifu;
               if (arb_lsu && !io_respValid) begin
                  next_state = ARB_BUSY_LSU;
               end else if (arb_ifu && !io_respValid) begin
                  next_state = ARB_BUSY_IFU;
               end
            end
            ARB_BUSY_IFU: begin
               sel_ifu = 1'b1;
               if (io_respValid) begin
                  next_state = ARB_IDLE;
               end
            end
            ARB_BUSY_LSU: begin
               sel_lsu = 1'b1;
               if (io_respValid) begin
                  next_state = ARB_IDLE;
               end
            end
            default: begin
               next_state = ARB_IDLE;
            end
         endcase
      end
      // Only the owner of the bus ever sees a response; the LSU latches
      // read data on any response, so a leaked IFU response would corrupt
      // the halves of a misaligned load.
      if (sel_lsu) begin
         io_reqValid   = 1'b1;
         io_addr       = lsu_addr;
         io_wdata      = lsu_wdata;
         io_size       = lsu_size;
         io_wen        = lsu_wen;
         io_wmask      = lsu_wmask;
         lsu_respValid = io_respValid;
      end else if (sel_ifu) begin
         io_reqValid   = 1'b1;
         io_addr       = ifu_addr;
         io_size       = LSU_WORD;
         ifu_respValid = io_respValid;
      end
   end

   // State register and starvation counter. The counter tracks consecutive
   // IDLE arbitrations the IFU lost while requesting, and restarts whenever
   // the IFU is granted or stops asking.
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= ARB_IDLE;
         wait_cnt <= '0;
      end else begin
         state <= next_state;
         if (state == ARB_IDLE) begin
            if (arb_ifu || !ifu_reqValid) begin
               wait_cnt <= '0;
            end else if (arb_lsu && (wait_cnt != MAX_WAIT)) begin
               wait_cnt <= wait_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter. A small bridge model answers each bus
//   request after 'latency' cycles (0 = same cycle) and returns
//   io_addr + 0x1000_0000 as read data.
// ---------------------------------------------------------------------------
import soc_pkg::*;

module tb_mem_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        ifu_reqValid;
   logic        ifu_respValid;
   logic [31:0] ifu_addr;
   logic [31:0] ifu_rdata;
   logic        lsu_reqValid;
   logic        lsu_respValid;
   logic [31:0] lsu_addr;
   logic [31:0] lsu_wdata;
   logic [1:0]  lsu_size;
   logic        lsu_wen;
   logic [3:0]  lsu_wmask;
   logic [31:0] lsu_rdata;
   logic        io_reqValid;
   logic        io_respValid;
   logic [31:0] io_addr;
   logic [31:0] io_wdata;
   logic [1:0]  io_size;
   logic        io_wen;
   logic [3:0]  io_wmask;
   logic [31:0] io_rdata;

   int          latency = 1;
   int          bcnt = 0;

   int          passCnt = 0;
   int          totalCnt = 0;
   int          reqCycles;
   int          ifuDone;
   int          lsuDone;
   int          bothResp;
   string       order;
   logic [31:0] lastIfuAddr;
   logic [31:0] lastIfuData;
   logic [31:0] lastIfuCtl;
   logic [31:0] lastIfuWdata;
   logic [31:0] lastLsuData;
   logic [31:0] part1Data;
   bit          keepIfu = 1'b0;
   bit          keepLsu = 1'b0;
   int          firstWins;
   int          loops;

   mem_arbiter #(.IFU_MAX_WAIT(4), .CNT_W(3)) dut (
      .clock        (clock),
      .reset        (reset),
      .ifu_reqValid (ifu_reqValid),
      .ifu_respValid(ifu_respValid),
      .ifu_addr     (ifu_addr),
      .ifu_rdata    (ifu_rdata),
      .lsu_reqValid (lsu_reqValid),
      .lsu_respValid(lsu_respValid),
      .lsu_addr     (lsu_addr),
      .lsu_wdata    (lsu_wdata),
      .lsu_size     (lsu_size),
      .lsu_wen      (lsu_wen),
      .lsu_wmask    (lsu_wmask),
      .lsu_rdata    (lsu_rdata),
      .io_reqValid  (io_reqValid),
      .io_respValid (io_respValid),
      .io_addr      (io_addr),
      .io_wdata     (io_wdata),
      .io_size      (io_size),
      .io_wen       (io_wen),
      .io_wmask     (io_wmask),
      .io_rdata     (io_rdata)
   );

   always #5 clock = ~clock;

   // Bridge model: counts cycles a request has been waiting and answers
   // once the count reaches the configured latency.
   always @(posedge clock) begin
      if (reset || !io_reqValid || io_respValid) begin
         bcnt <= 0;
      end else begin
         bcnt <= bcnt + 1;
      end
   end

   assign io_respValid = io_reqValid && (bcnt == latency);
   assign io_rdata     = io_addr + 32'h1000_0000;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      totalCnt++;
      assert (obs === exp) passCnt++;
      else $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
   endtask

   task automatic applyStimulus(input logic ifuReq, input logic [31:0] iAddr,
                                input logic lsuReq, input logic [31:0] lAddr,
                                input logic [31:0] lWdata, input logic [1:0] lSize,
                                input logic lWen, input logic [3:0] lWmask);
      ifu_reqValid = ifuReq;
      ifu_addr     = iAddr;
      lsu_reqValid = lsuReq;
      lsu_addr     = lAddr;
      lsu_wdata    = lWdata;
      lsu_size     = lSize;
      lsu_wen      = lWen;
      lsu_wmask    = lWmask;
   endtask

   task automatic clearStats();
      reqCycles = 0;
      ifuDone   = 0;
      lsuDone   = 0;
      bothResp  = 0;
      order     = "";
   endtask

   // One clock: observe at the falling edge, then let each requester drop
   // its request after a completion unless it has another one queued.
   task automatic runCycle();
      bit ifuSeen;
      bit lsuSeen;
      @(negedge clock);
      ifuSeen = 1'b0;
      lsuSeen = 1'b0;
      if (io_reqValid) reqCycles++;
      if (ifu_respValid && lsu_respValid) bothResp++;
      if (ifu_respValid) begin
         ifuDone++;
         order        = {order, "I"};
         lastIfuAddr  = io_addr;
         lastIfuData  = ifu_rdata;
         lastIfuCtl   = {25'b0, io_size, io_wen, io_wmask};
         lastIfuWdata = io_wdata;
         ifuSeen      = 1'b1;
      end
      if (lsu_respValid) begin
         lsuDone++;
         order       = {order, "L"};
         lastLsuData = lsu_rdata;
         lsuSeen     = 1'b1;
      end
      @(posedge clock);
      #1;
      if (ifuSeen && !keepIfu) ifu_reqValid = 1'b0;
      if (lsuSeen && !keepLsu) lsu_reqValid = 1'b0;
   endtask

   task automatic drain();
      keepIfu = 1'b0;
      keepLsu = 1'b0;
      loops = 0;
      while ((ifu_reqValid || lsu_reqValid) && loops < 40) begin
         runCycle();
         loops++;
      end
      runCycle();
   endtask

   initial begin
      // Reset with both requesters asking: the bus must stay silent.
      reset = 1'b1;
      applyStimulus(1'b1, 32'h8000_0000, 1'b1, 32'h100, 32'h0, LSU_WORD, 1'b0, 4'hF);
      @(posedge clock); #1;
      @(posedge clock); #1;
      checkOutput("rst_ioReq",   io_reqValid,   1'b0);
      checkOutput("rst_ifuResp", ifu_respValid, 1'b0);
      checkOutput("rst_lsuResp", lsu_respValid, 1'b0);
      checkOutput("rst_ioAddr",  io_addr,       32'h0);
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, LSU_BYTE, 1'b0, 4'h0);
      reset = 1'b0;
      @(posedge clock); #1;
      checkOutput("idle_ioReq",  io_reqValid,   1'b0);
      checkOutput("idle_ioAddr", io_addr,       32'h0);

      // 1: IFU alone, bridge latency 2. LSU fields are non-zero but idle so
      // the IFU's fixed attributes are visible on the bus.
      $display("[TB] test 1: IFU only");
      latency = 2;
      clearStats();
      applyStimulus(1'b1, 32'h8000_0000, 1'b0, 32'h0, 32'h1234_5678, LSU_BYTE, 1'b1, 4'hF);
      loops = 0;
      while (ifuDone == 0 && loops < 20) begin runCycle(); loops++; end
      runCycle();
      runCycle();
      checkOutput("t1_ifuDone",   ifuDone,      1);
      checkOutput("t1_reqCycles", reqCycles,    3);
      checkOutput("t1_lsuDone",   lsuDone,      0);
      checkOutput("t1_rdata",     lastIfuData,  32'h9000_0000);
      checkOutput("t1_ifuCtl",    lastIfuCtl,   32'h0000_0040);
      checkOutput("t1_ifuWdata",  lastIfuWdata, 32'h0);

      // 2: simultaneous requests, LSU first then IFU immediately after.
      $display("[TB] test 2: IFU and LSU together");
      latency = 1;
      clearStats();
      applyStimulus(1'b1, 32'h8000_0004, 1'b1, 32'h100, 32'h0, LSU_WORD, 1'b0, 4'hF);
      #1;
      checkOutput("t2_firstAddr", io_addr, 32'h100);
      checkOutput("t2_firstSize", io_size, 2'b10);
      loops = 0;
      while ((ifuDone == 0 || lsuDone == 0) && loops < 30) begin runCycle(); loops++; end
      checkOutput("t2_cycles",   loops,       4);
      checkOutput("t2_order0",   order[0],    "L");
      checkOutput("t2_order1",   order[1],    "I");
      checkOutput("t2_lsuData",  lastLsuData, 32'h1000_0100);
      checkOutput("t2_ifuAddr",  lastIfuAddr, 32'h8000_0004);
      checkOutput("t2_bothResp", bothResp,    0);
      drain();

      // 3: LSU requests back to back with IFU always pending; IFU wins
      // every fifth arbitration, twice in a row.
      $display("[TB] test 3: starvation guard");
      latency = 1;
      clearStats();
      keepIfu = 1'b1;
      keepLsu = 1'b1;
      firstWins = -1;
      applyStimulus(1'b1, 32'h8000_0008, 1'b1, 32'h110, 32'h0, LSU_WORD, 1'b0, 4'hF);
      loops = 0;
      while (ifuDone < 2 && loops < 100) begin
         runCycle();
         if (ifuDone == 1 && firstWins < 0) firstWins = lsuDone;
         loops++;
      end
      checkOutput("t3_ifuDone",    ifuDone,             2);
      checkOutput("t3_firstWins",  firstWins,           4);
      checkOutput("t3_secondWins", lsuDone - firstWins, 4);
      checkOutput("t3_order4",     order[4],            "I");
      drain();

      // 4: zero-latency store completes in its request cycle and the
      // arbiter is free again on the very next cycle.
      $display("[TB] test 4: zero latency store");
      latency = 0;
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h200, 32'hDEAD_BEEF, LSU_WORD, 1'b1, 4'hF);
      #1;
      checkOutput("t4_lsuResp", lsu_respValid, 1'b1);
      checkOutput("t4_ifuResp", ifu_respValid, 1'b0);
      checkOutput("t4_ioAddr",  io_addr,       32'h200);
      checkOutput("t4_ioWdata", io_wdata,      32'hDEAD_BEEF);
      checkOutput("t4_ioWen",   io_wen,        1'b1);
      checkOutput("t4_ioWmask", io_wmask,      4'hF);
      @(posedge clock); #1;
      applyStimulus(1'b1, 32'h8000_0040, 1'b0, 32'h0, 32'h0, LSU_WORD, 1'b0, 4'h0);
      #1;
      checkOutput("t4_nextAddr",    io_addr,       32'h8000_0040);
      checkOutput("t4_nextIfuResp", ifu_respValid, 1'b1);
      checkOutput("t4_nextLsuResp", lsu_respValid, 1'b0);
      @(posedge clock); #1;
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, LSU_WORD, 1'b0, 4'h0);
      #1;
      checkOutput("t4_quiet", io_reqValid, 1'b0);

      // 5: misaligned load split into 0x100 and 0x104; IFU slots between.
      $display("[TB] test 5: misaligned load with IFU pending");
      latency = 1;
      clearStats();
      applyStimulus(1'b1, 32'h8000_0080, 1'b1, 32'h100, 32'h0, LSU_WORD, 1'b0, 4'hF);
      loops = 0;
      while (lsuDone == 0 && loops < 20) begin runCycle(); loops++; end
      part1Data = lastLsuData;
      runCycle();
      lsu_addr     = 32'h104;
      lsu_reqValid = 1'b1;
      loops = 0;
      while ((lsuDone < 2 || ifuDone < 1) && loops < 20) begin runCycle(); loops++; end
      runCycle();
      checkOutput("t5_part1",    part1Data,   32'h1000_0100);
      checkOutput("t5_part2",    lastLsuData, 32'h1000_0104);
      checkOutput("t5_lsuDone",  lsuDone,     2);
      checkOutput("t5_ifuDone",  ifuDone,     1);
      checkOutput("t5_order1",   order[1],    "I");
      checkOutput("t5_ifuData",  lastIfuData, 32'h9000_0080);
      checkOutput("t5_bothResp", bothResp,    0);

      // 6: build the starvation count to its limit, reset inside the LSU
      // transaction, and confirm the count restarted (LSU wins again).
      $display("[TB] test 6: reset while busy");
      latency = 1;
      clearStats();
      keepIfu = 1'b1;
      keepLsu = 1'b1;
      applyStimulus(1'b1, 32'h8000_00C0, 1'b1, 32'h300, 32'h0, LSU_WORD, 1'b0, 4'hF);
      loops = 0;
      while (lsuDone < 3 && loops < 30) begin runCycle(); loops++; end
      checkOutput("t6_ifuDone", ifuDone, 0);
      latency = 5;
      #1;
      checkOutput("t6_busyReq",  io_reqValid, 1'b1);
      checkOutput("t6_busyAddr", io_addr,     32'h300);
      @(posedge clock); #1;
      reset = 1'b1;
      #1;
      checkOutput("t6_rstIoReq",   io_reqValid,   1'b0);
      checkOutput("t6_rstLsuResp", lsu_respValid, 1'b0);
      @(posedge clock); #1;
      reset   = 1'b0;
      keepIfu = 1'b0;
      keepLsu = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, LSU_WORD, 1'b0, 4'h0);
      #1;
      checkOutput("t6_postIoReq", io_reqValid, 1'b0);
      clearStats();
      runCycle();
      runCycle();
      runCycle();
      checkOutput("t6_quietReq", reqCycles, 0);
      checkOutput("t6_quietLsu", lsuDone,   0);
      checkOutput("t6_quietIfu", ifuDone,   0);
      latency = 1;
      applyStimulus(1'b1, 32'h8000_00C0, 1'b1, 32'h300, 32'h0, LSU_WORD, 1'b0, 4'hF);
      #1;
      checkOutput("t6_winnerAddr", io_addr, 32'h300);
      drain();

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
